// File: rtl/lfsr_rng_arbiter.sv
// Random-word server: reseeds an external LFSR, discards warm-up bits, assembles
// WIDTH-bit words and hands each one to a single requester chosen round-robin.
module lfsr_rng_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned WARMUP       = 200,
    parameter logic [27:0] SEED_DEFAULT = 28'h0000001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seed_load,
    input  logic [27:0]      seed_in,
    output logic             lfsr_rst,
    output logic [27:0]      lfsr_seed,
    input  logic             lfsr_bit,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [WIDTH-1:0] rnd_data,
    output logic             busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Shared counter: wide enough for WARMUP (<=1023) and WIDTH (<=64).
    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_WARM,
        ST_FILL,
        ST_READY
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   rnd_q, rnd_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [27:0]        seed_q, seed_d;
    logic               lfsr_rst_q, lfsr_rst_d;
    logic               busy_q, busy_d;

    logic               pick_found;
    logic [PTR_W-1:0]   pick_idx;
    logic [PTR_W-1:0]   cand;

    // Round-robin search starting at ptr_q (the slot after the last winner).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % int'(NREQ));
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        rnd_d   = rnd_q;
        gnt_d   = '0;
        ptr_d   = ptr_q;
        seed_d  = seed_q;

        if (seed_load) begin
            seed_d  = seed_in;
            state_d = ST_SEED;
            cnt_d   = '0;
            word_d  = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    state_d = ST_WARM;
                    cnt_d   = '0;
                end
                ST_WARM: begin
                    if (cnt_q == CNT_W'(WARMUP - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    word_d = {word_q[WIDTH-2:0], lfsr_bit};
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_READY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (pick_found) begin
                        gnt_d   = NREQ'(1) << pick_idx;
                        rnd_d   = word_q;
                        ptr_d   = (pick_idx == PTR_W'(NREQ - 1)) ? '0 : pick_idx + PTR_W'(1);
                        state_d = ST_FILL;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end

        lfsr_rst_d = (state_d == ST_SEED);
        busy_d     = (state_d != ST_READY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SEED;
            cnt_q      <= '0;
            word_q     <= '0;
            rnd_q      <= '0;
            gnt_q      <= '0;
            ptr_q      <= '0;
            seed_q     <= SEED_DEFAULT;
            lfsr_rst_q <= 1'b1;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_q     <= word_d;
            rnd_q      <= rnd_d;
            gnt_q      <= gnt_d;
            ptr_q      <= ptr_d;
            seed_q     <= seed_d;
            lfsr_rst_q <= lfsr_rst_d;
            busy_q     <= busy_d;
        end
    end

    assign lfsr_rst  = lfsr_rst_q;
    assign lfsr_seed = seed_q;
    assign gnt       = gnt_q;
    assign rnd_data  = rnd_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter (NREQ=4, WIDTH=16, WARMUP=200); the bench
// drives lfsr_bit itself and predicts each word and its edge from the schedule.
module tb_lfsr_rng_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned WARMUP = 200;

    logic             clk;
    logic             reset;
    logic             seed_load;
    logic [27:0]      seed_in;
    logic             lfsr_rst;
    logic [27:0]      lfsr_seed;
    logic             lfsr_bit;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  gnt;
    logic [WIDTH-1:0] rnd_data;
    logic             busy;

    int n_tests;
    int n_fail;

    lfsr_rng_arbiter #(
        .NREQ        (NREQ),
        .WIDTH       (WIDTH),
        .WARMUP      (WARMUP),
        .SEED_DEFAULT(28'h0000001)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .lfsr_rst (lfsr_rst),
        .lfsr_seed(lfsr_seed),
        .lfsr_bit (lfsr_bit),
        .req      (req),
        .gnt      (gnt),
        .rnd_data (rnd_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".lfsr_rst"}, 64'(lfsr_rst), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        chk({tag, ".gnt"}, 64'(gnt), 64'd0);
        chk({tag, ".rnd"}, 64'(rnd_data), 64'd0);
        chk({tag, ".seed"}, 64'(lfsr_seed), 64'h0000001);
    endtask

    // Shift a word in MSB-first across the 16 FILL edges.
    task automatic fill_word(input string tag, input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            lfsr_bit = w[4'(15 - i)];
            step();
            if (i == 0)  chk({tag, ".gnt_pulse"}, 64'(gnt), 64'd0);
            if (i == 14) chk({tag, ".busy_fill"}, 64'(busy), 64'd1);
            if (i == 15) begin
                chk({tag, ".busy_ready"}, 64'(busy), 64'd0);
                chk({tag, ".gnt_ready"}, 64'(gnt), 64'd0);
            end
        end
    endtask

    // From SEED: one SEED edge, WARMUP ignored random bits, then the word.
    task automatic bringup(input string tag, input logic [15:0] w);
        step();
        chk({tag, ".rst_fell"}, 64'(lfsr_rst), 64'd0);
        chk({tag, ".busy_warm"}, 64'(busy), 64'd1);
        for (int i = 0; i < int'(WARMUP); i++) begin
            lfsr_bit = 1'($urandom);
            step();
            if (i == 100) chk({tag, ".gnt_warm"}, 64'(gnt), 64'd0);
        end
        fill_word(tag, w);
    endtask

    logic [15:0] words [5];
    logic [3:0]  exp_gnt [5];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        seed_load = 1'b0;
        seed_in   = '0;
        req       = '0;
        lfsr_bit  = 1'b0;
        words     = '{16'hA5C3, 16'h1234, 16'hBEEF, 16'h0F0F, 16'h8001};
        exp_gnt   = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        step();
        step();
        chk_reset_outputs("reset");

        // Seed load under reset is ignored.
        seed_load = 1'b1;
        seed_in   = 28'hABCDEF1;
        step();
        seed_load = 1'b0;
        chk("reset_seedload.seed", 64'(lfsr_seed), 64'h0000001);

        // Bring-up with no requests: READY after edge 217, stays idle.
        reset = 1'b0;
        chk("release.rst_pre_edge", 64'(lfsr_rst), 64'd1);
        bringup("bringup", words[0]);
        for (int i = 0; i < 5; i++) begin
            lfsr_bit = 1'($urandom);
            step();
        end
        chk("idle.gnt", 64'(gnt), 64'd0);
        chk("idle.busy", 64'(busy), 64'd0);
        chk("idle.seed", 64'(lfsr_seed), 64'h0000001);
        chk("idle.rnd", 64'(rnd_data), 64'd0);

        // Continuous all-request: round robin, one grant every 17 edges.
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr%0d.gnt", k), 64'(gnt), 64'(exp_gnt[k]));
            chk($sformatf("rr%0d.rnd", k), 64'(rnd_data), 64'(words[k]));
            chk($sformatf("rr%0d.busy", k), 64'(busy), 64'd1);
            if (k < 4) fill_word($sformatf("rr%0d", k), words[k + 1]);
        end

        // Single requester 2 receives the 16'hA5C3 pattern.
        req = 4'b0100;
        fill_word("single", 16'hA5C3);
        step();
        chk("single.gnt", 64'(gnt), 64'b0100);
        chk("single.rnd", 64'(rnd_data), 64'hA5C3);
        req = 4'b0000;

        // Reseed at FILL cycle 8: no grant, restart, READY 217 edges later.
        for (int i = 0; i < 8; i++) begin
            lfsr_bit = 1'($urandom);
            step();
        end
        chk("single.rnd_hold", 64'(rnd_data), 64'hA5C3);
        seed_load = 1'b1;
        seed_in   = 28'hABCDEF1;
        req       = 4'b0010;
        step();
        seed_load = 1'b0;
        chk("reseed.gnt", 64'(gnt), 64'd0);
        chk("reseed.seed", 64'(lfsr_seed), 64'hABCDEF1);
        chk("reseed.lfsr_rst", 64'(lfsr_rst), 64'd1);
        chk("reseed.busy", 64'(busy), 64'd1);
        bringup("reseed", 16'h3C96);
        step();
        chk("reseed_grant.gnt", 64'(gnt), 64'b0010);
        chk("reseed_grant.rnd", 64'(rnd_data), 64'h3C96);
        req = 4'b0000;
        fill_word("refill", 16'h7E81);

        // seed_load wins over a pending grant in READY.
        seed_load = 1'b1;
        seed_in   = 28'h1234567;
        req       = 4'b0001;
        step();
        seed_load = 1'b0;
        chk("collide.gnt", 64'(gnt), 64'd0);
        chk("collide.seed", 64'(lfsr_seed), 64'h1234567);
        chk("collide.lfsr_rst", 64'(lfsr_rst), 64'd1);
        chk("collide.rnd", 64'(rnd_data), 64'h3C96);
        bringup("collide", 16'h5A5A);
        step();
        chk("collide_grant.gnt", 64'(gnt), 64'b0001);
        chk("collide_grant.rnd", 64'(rnd_data), 64'h5A5A);

        // Mid-FILL reset: pointer is at 1, so req 1001 would go to 3 without it.
        req = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            lfsr_bit = 1'($urandom);
            step();
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_reset_outputs($sformatf("midreset%0d", i));
        end
        reset = 1'b0;
        bringup("post_reset", 16'hC3A5);
        step();
        chk("post_reset.gnt", 64'(gnt), 64'b0001);
        chk("post_reset.rnd", 64'(rnd_data), 64'hC3A5);
        chk("post_reset.seed", 64'(lfsr_seed), 64'h0000001);
        step();
        chk("post_reset.gnt_pulse", 64'(gnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
